// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: port ids,
// alignment rule and pipeline-stage control records.
package dmem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_e;

    // Word accesses only: any set bit under this mask marks a misaligned address.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        port_id_e port;
        logic     we;
        logic     err;
    } acc_ctl_t;

    typedef struct packed {
        port_id_e port;
        logic     err;
    } rsp_ctl_t;

    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer always moves to the port
// that lost (or did not ask) on the last grant, and holds when idle.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_id_e ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst) begin
            if (req_i == 2'b11)
                gnt_o = (ptr_q == PORT_DMA) ? 2'b10 : 2'b01;
            else
                gnt_o = req_i;
        end
        ptr_d = ptr_q;
        if (gnt_o[0])
            ptr_d = PORT_DMA;
        else if (gnt_o[1])
            ptr_d = PORT_CPU;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= PORT_CPU;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter: ACCEPT -> ACCESS -> RESP pipeline,
// one request per cycle, fixed two-cycle response latency.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    output logic              p0_rsp_err,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic              p1_rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        gnt;
    logic              sel_dma;

    logic              acc_vld_q, acc_vld_d;
    acc_ctl_t          acc_ctl_q, acc_ctl_d;
    logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;

    logic              rsp_vld_q, rsp_vld_d;
    rsp_ctl_t          rsp_ctl_q, rsp_ctl_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              mem_go;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({p1_valid, p0_valid}),
        .gnt_o (gnt)
    );

    assign p0_ready = gnt[0];
    assign p1_ready = gnt[1];
    assign sel_dma  = gnt[1];

    // ACCEPT: mux the granted request into the access stage.
    always_comb begin
        acc_vld_d         = |gnt;
        acc_addr_d        = sel_dma ? p1_addr  : p0_addr;
        acc_wdata_d       = sel_dma ? p1_wdata : p0_wdata;
        acc_ctl_d.port    = sel_dma ? PORT_DMA : PORT_CPU;
        acc_ctl_d.we      = sel_dma ? p1_we    : p0_we;
        acc_ctl_d.err     = misaligned(acc_addr_d[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_vld_q   <= 1'b0;
            acc_ctl_q   <= '0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
        end else begin
            acc_vld_q <= acc_vld_d;
            if (acc_vld_d) begin
                acc_ctl_q   <= acc_ctl_d;
                acc_addr_q  <= acc_addr_d;
                acc_wdata_q <= acc_wdata_d;
            end
        end
    end

    // ACCESS: rst gates the strobe so an aborted in-flight write never lands.
    assign mem_go    = acc_vld_q & ~acc_ctl_q.err & ~rst;
    assign mem_ce    = mem_go;
    assign mem_we    = mem_go & acc_ctl_q.we;
    assign mem_addr  = mem_go ? acc_addr_q  : '0;
    assign mem_wdata = mem_go ? acc_wdata_q : '0;

    always_comb begin
        rsp_vld_d      = acc_vld_q;
        rsp_ctl_d.port = acc_ctl_q.port;
        rsp_ctl_d.err  = acc_ctl_q.err;
        rsp_rdata_d    = (mem_go && !acc_ctl_q.we) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q   <= 1'b0;
            rsp_ctl_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_vld_q   <= rsp_vld_d;
            rsp_ctl_q   <= rsp_ctl_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // RESP: single-cycle strobe routed to the owning port only.
    assign p0_rsp_valid = rsp_vld_q & ~rst & (rsp_ctl_q.port == PORT_CPU);
    assign p1_rsp_valid = rsp_vld_q & ~rst & (rsp_ctl_q.port == PORT_DMA);
    assign p0_rsp_err   = p0_rsp_valid & rsp_ctl_q.err;
    assign p1_rsp_err   = p1_rsp_valid & rsp_ctl_q.err;
    assign rsp_rdata    = (rsp_vld_q && !rst) ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory model attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        init_mem;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
        .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (mem_ce && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        #2;
    endtask

    task automatic idle;
        p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    endtask

    task automatic drv0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    task automatic pulse_reset;
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        init_mem = 1;
        drv0(1, 0, 32'h10, 0);
        drv1(1, 1, 32'h20, 32'h5);
        tick();
        init_mem = 0;
        tick();
        sample();
        vectors++;
        if ({p0_ready, p1_ready, mem_ce, mem_we, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 00000000",
                     {p0_ready, p1_ready, mem_ce, mem_we, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err});
        end
        vectors++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want all 0", mem_addr, mem_wdata, rsp_rdata);
        end
        idle();
        tick();
        rst = 0;
    endtask

    task automatic test_write_read;
        drv0(1, 1, 32'h10, 32'hDEAD_BEEF);
        sample();
        vectors++;
        if ({p1_ready, p0_ready} !== 2'b01) begin
            miscompares++; $display("FAIL wr_grant: got %b want 01", {p1_ready, p0_ready});
        end
        tick();
        drv0(1, 0, 32'h10, 0);
        sample();
        vectors++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata, p0_ready} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_access: ce %b we %b addr %h wdata %h rdy %b want 1 1 00000010 deadbeef 1",
                     mem_ce, mem_we, mem_addr, mem_wdata, p0_ready);
        end
        tick();
        idle();
        sample();
        vectors++;
        if ({p0_rsp_valid, p0_rsp_err, rsp_rdata, mem_ce, mem_we} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_resp: vld %b err %b rdata %h ce %b we %b want 1 0 00000000 1 0",
                     p0_rsp_valid, p0_rsp_err, rsp_rdata, mem_ce, mem_we);
        end
        tick();
        sample();
        vectors++;
        if ({p0_rsp_valid, p0_rsp_err, p1_rsp_valid, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL rd_after_wr: vld %b err %b p1vld %b rdata %h want 1 0 0 deadbeef",
                     p0_rsp_valid, p0_rsp_err, p1_rsp_valid, rsp_rdata);
        end
        tick();
        sample();
        vectors++;
        if (p0_rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL rsp_one_cycle: got %b want 0", p0_rsp_valid);
        end
        tick();
    endtask

    task automatic test_round_robin;
        int c0, c1;
        c0 = 0; c1 = 0;
        pulse_reset();
        drv0(1, 0, 32'h10, 0);
        drv1(1, 0, 32'h14, 0);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) idle();
            sample();
            if (k < 8) begin
                vectors++;
                if ({p1_ready, p0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", k, {p1_ready, p0_ready},
                             (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            vectors++;
            if ({p1_rsp_valid, p0_rsp_valid} !== ((k < 2) ? 2'b00 : (k % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL rr_rsp[%0d]: got %b", k, {p1_rsp_valid, p0_rsp_valid});
            end
            if (p0_rsp_valid) begin
                c0++;
                vectors++;
                if (rsp_rdata !== 32'hDEAD_BEEF) begin
                    miscompares++; $display("FAIL rr_p0_data[%0d]: got %h want deadbeef", k, rsp_rdata);
                end
            end
            if (p1_rsp_valid) begin
                c1++;
                vectors++;
                if (rsp_rdata !== 32'hA000_0005) begin
                    miscompares++; $display("FAIL rr_p1_data[%0d]: got %h want a0000005", k, rsp_rdata);
                end
            end
            tick();
        end
        vectors++;
        if (c0 !== 4 || c1 !== 4) begin
            miscompares++; $display("FAIL rr_counts: p0 %0d p1 %0d want 4 4", c0, c1);
        end
    endtask

    task automatic test_misaligned;
        drv1(1, 0, 32'h06, 0);
        sample();
        vectors++;
        if ({p1_ready, p0_ready} !== 2'b10) begin
            miscompares++; $display("FAIL mis_grant: got %b want 10", {p1_ready, p0_ready});
        end
        tick();
        idle();
        sample();
        vectors++;
        if ({mem_ce, mem_we, mem_addr} !== 34'b0) begin
            miscompares++; $display("FAIL mis_access: ce %b we %b addr %h want 0 0 0", mem_ce, mem_we, mem_addr);
        end
        tick();
        sample();
        vectors++;
        if ({p1_rsp_valid, p1_rsp_err, p0_rsp_valid, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL mis_resp: vld %b err %b p0vld %b rdata %h want 1 1 0 00000000",
                     p1_rsp_valid, p1_rsp_err, p0_rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_cross_port;
        drv1(1, 1, 32'h20, 32'h1234_5678);
        sample();
        vectors++;
        if (p1_ready !== 1'b1) begin
            miscompares++; $display("FAIL xp_wgrant: got %b want 1", p1_ready);
        end
        tick();
        idle();
        drv0(1, 0, 32'h20, 0);
        sample();
        vectors++;
        if ({p1_ready, p0_ready} !== 2'b01) begin
            miscompares++; $display("FAIL xp_rgrant: got %b want 01", {p1_ready, p0_ready});
        end
        tick();
        idle();
        sample();
        vectors++;
        if ({p1_rsp_valid, p1_rsp_err, p0_rsp_valid} !== 3'b100) begin
            miscompares++; $display("FAIL xp_wresp: got %b want 100", {p1_rsp_valid, p1_rsp_err, p0_rsp_valid});
        end
        tick();
        sample();
        vectors++;
        if ({p0_rsp_valid, p1_rsp_valid, rsp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL xp_rdata: vld %b p1vld %b rdata %h want 1 0 12345678", p0_rsp_valid, p1_rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [3];
        logic [31:0] e [3];
        a = '{32'h10, 32'h14, 32'h20};
        e = '{32'hDEAD_BEEF, 32'hA000_0005, 32'h1234_5678};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drv0(1, 0, a[k], 0); else idle();
            sample();
            if (k < 3) begin
                vectors++;
                if ({p1_ready, p0_ready} !== 2'b01) begin
                    miscompares++; $display("FAIL b2b_grant[%0d]: got %b want 01", k, {p1_ready, p0_ready});
                end
            end
            if (k >= 2) begin
                vectors++;
                if ({p0_rsp_valid, rsp_rdata} !== {1'b1, e[k-2]}) begin
                    miscompares++;
                    $display("FAIL b2b_rsp[%0d]: vld %b rdata %h want 1 %h", k, p0_rsp_valid, rsp_rdata, e[k-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_abort;
        // Leave the pointer at DMA so the post-reset grant proves it was cleared.
        drv0(1, 1, 32'h30, 32'hCAFE_F00D);
        sample();
        vectors++;
        if (p0_ready !== 1'b1) begin
            miscompares++; $display("FAIL abort_grant: got %b want 1", p0_ready);
        end
        tick();
        idle();
        rst = 1;
        sample();
        vectors++;
        if ({mem_ce, mem_we} !== 2'b00) begin
            miscompares++; $display("FAIL abort_access: ce %b we %b want 0 0", mem_ce, mem_we);
        end
        tick();
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            sample();
            vectors++;
            if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin
                miscompares++; $display("FAIL abort_norsp[%0d]: got %b want 00", k, {p0_rsp_valid, p1_rsp_valid});
            end
            tick();
        end
        vectors++;
        if (mem[12] !== 32'hA000_000C) begin
            miscompares++; $display("FAIL abort_mem: got %h want a000000c", mem[12]);
        end
        drv0(1, 0, 32'h10, 0);
        drv1(1, 0, 32'h14, 0);
        sample();
        vectors++;
        if ({p1_ready, p0_ready} !== 2'b01) begin
            miscompares++; $display("FAIL abort_ptr: got %b want 01", {p1_ready, p0_ready});
        end
        tick();
        idle();
        tick();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_misaligned();
        test_cross_port();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
